// File: rtl/perceptron_operand_loader_if.sv
// Stream and result handshakes between the host side and the perceptron operand loader.
// The master modport is the host/DMA side; the slave modport is the loader.
interface perceptron_operand_loader_if #(
  parameter int W = 16
);
  logic signed [W-1:0] s_data;
  logic                s_valid;
  logic                s_last;
  logic                s_ready;
  logic                reuse_coeffs;
  logic signed [2*W:0] result_data;
  logic                result_valid;
  logic                result_ready;

  modport master (
    output s_data, s_valid, s_last, reuse_coeffs, result_ready,
    input  s_ready, result_data, result_valid
  );

  modport slave (
    input  s_data, s_valid, s_last, reuse_coeffs, result_ready,
    output s_ready, result_data, result_valid
  );
endinterface

// File: rtl/perceptron_operand_loader.sv
// Packs a serial operand stream into the perceptron's parallel input/coefficient buses,
// waits for the combinational result to settle, and hands the classification back.
//
// state       | meaning
// S_LOAD_IN   | accepting input words, slot = word counter
// S_LOAD_CF   | accepting coefficient words, slot = word counter
// S_SETTLE    | stream stalled, waiting for the perceptron to settle
// S_PRESENT   | result_valid high, holding result_data until result_ready
module perceptron_operand_loader #(
  parameter int N      = 50,
  parameter int W      = 16,
  parameter int SETTLE = 1
) (
  input  logic                clk,
  input  logic                rst,
  perceptron_operand_loader_if.slave sif,
  output logic [N*W-1:0]      inputs_flat,
  output logic [N*W-1:0]      coeffs_flat,
  input  logic signed [2*W:0] classification,
  output logic                frame_err
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam int SW = $clog2(SETTLE + 1);
  localparam logic [CW-1:0] LAST_IDX  = CW'(N - 1);
  localparam logic [SW-1:0] SETTLE_LD = SW'(SETTLE);

  typedef enum logic [1:0] {
    S_LOAD_IN  = 2'd0,
    S_LOAD_CF  = 2'd1,
    S_SETTLE   = 2'd2,
    S_PRESENT  = 2'd3
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] word_cnt;
  logic [SW-1:0] settle_cnt;
  logic          coeff_loaded;
  logic          reuse_q;
  logic          reuse_now;
  logic          fire;
  logic          last_word;
  logic          frame_bad;
  logic          capture;

  assign sif.s_ready = ~rst & ((state == S_LOAD_IN) | (state == S_LOAD_CF));
  assign fire        = sif.s_valid & sif.s_ready;

  // Reuse is decided once, on the word-0 handshake, and held for the rest of the frame.
  assign reuse_now = (word_cnt == '0) ? (sif.reuse_coeffs & coeff_loaded) : reuse_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_LOAD_IN;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    last_word = 1'b0;
    frame_bad = 1'b0;
    capture   = 1'b0;
    case (state)
      S_LOAD_IN: begin
        last_word = (word_cnt == LAST_IDX) & reuse_now;
        if (fire) begin
          if (sif.s_last != last_word) begin
            frame_bad = 1'b1;
            state_nxt = S_LOAD_IN;
          end else if (word_cnt == LAST_IDX) begin
            state_nxt = reuse_now ? S_SETTLE : S_LOAD_CF;
          end
        end
      end
      S_LOAD_CF: begin
        last_word = (word_cnt == LAST_IDX);
        if (fire) begin
          if (sif.s_last != last_word) begin
            frame_bad = 1'b1;
            state_nxt = S_LOAD_IN;
          end else if (last_word) begin
            state_nxt = S_SETTLE;
          end
        end
      end
      S_SETTLE: begin
        if (settle_cnt == '0) begin
          capture   = 1'b1;
          state_nxt = S_PRESENT;
        end
      end
      S_PRESENT: begin
        if (sif.result_ready) state_nxt = S_LOAD_IN;
      end
      default: state_nxt = S_LOAD_IN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inputs_flat      <= '0;
      coeffs_flat      <= '0;
      word_cnt         <= '0;
      settle_cnt       <= '0;
      coeff_loaded     <= 1'b0;
      reuse_q          <= 1'b0;
      frame_err        <= 1'b0;
      sif.result_data  <= '0;
      sif.result_valid <= 1'b0;
    end else begin
      frame_err <= frame_bad;

      // The error word is still stored; operand buses keep whatever arrived.
      if (fire) begin
        if (state == S_LOAD_IN) begin
          inputs_flat[int'(word_cnt)*W +: W] <= sif.s_data;
          if (word_cnt == '0) reuse_q <= reuse_now;
        end else begin
          coeffs_flat[int'(word_cnt)*W +: W] <= sif.s_data;
        end

        if (frame_bad || (word_cnt == LAST_IDX)) word_cnt <= '0;
        else                                     word_cnt <= word_cnt + 1'b1;

        if (state == S_LOAD_CF) begin
          if (frame_bad)                  coeff_loaded <= 1'b0;
          else if (word_cnt == LAST_IDX)  coeff_loaded <= 1'b1;
        end
      end

      if ((state_nxt == S_SETTLE) && (state != S_SETTLE)) settle_cnt <= SETTLE_LD;
      else if ((state == S_SETTLE) && (settle_cnt != '0)) settle_cnt <= settle_cnt - 1'b1;

      if (capture) begin
        sif.result_data  <= classification;
        sif.result_valid <= 1'b1;
      end else if ((state == S_PRESENT) && sif.result_ready) begin
        sif.result_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_perceptron_operand_loader.sv
// Directed and randomized frames against a slot-array model of the operand loader,
// with a behavioural 50-input perceptron closing the loop on the parallel buses.
module tb_perceptron_operand_loader;
  localparam int N      = 50;
  localparam int W      = 16;
  localparam int SETTLE = 1;

  logic clk = 1'b0;
  logic rst;
  logic [N*W-1:0]      inputs_flat;
  logic [N*W-1:0]      coeffs_flat;
  logic signed [2*W:0] classification;
  logic                frame_err;

  perceptron_operand_loader_if #(.W(W)) sif ();

  perceptron_operand_loader #(.N(N), .W(W), .SETTLE(SETTLE)) dut (
    .clk            (clk),
    .rst            (rst),
    .sif            (sif),
    .inputs_flat    (inputs_flat),
    .coeffs_flat    (coeffs_flat),
    .classification (classification),
    .frame_err      (frame_err)
  );

  always #5 clk = ~clk;

  // Combinational perceptron: sum of products, truncated to its 33-bit output.
  always_comb begin
    longint acc;
    acc = 0;
    for (int i = 0; i < N; i++)
      acc += longint'($signed(inputs_flat[i*W +: W])) * longint'($signed(coeffs_flat[i*W +: W]));
    classification = acc[2*W:0];
  end

  int checks   = 0;
  int failures = 0;

  int ref_in [N];
  int ref_cf [N];
  bit cf_loaded_m;
  int frame_in [N];
  int frame_cf [N];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [N*W-1:0] pack(input int a [N]);
    logic [N*W-1:0] p;
    p = '0;
    for (int i = 0; i < N; i++) p[i*W +: W] = W'(a[i]);
    return p;
  endfunction

  function automatic logic signed [2*W:0] model_result();
    longint acc;
    acc = 0;
    for (int i = 0; i < N; i++)
      acc += longint'(ref_in[i]) * longint'(ref_cf[i]);
    return acc[2*W:0];
  endfunction

  task automatic chk_buses(input string tag);
    logic [N*W-1:0] pi, pc;
    pi = pack(ref_in);
    pc = pack(ref_cf);
    checks++;
    assert (inputs_flat === pi) else begin
      failures++;
      $error("FAIL %s_inputs observed=%0h expected=%0h", tag, inputs_flat, pi);
    end
    checks++;
    assert (coeffs_flat === pc) else begin
      failures++;
      $error("FAIL %s_coeffs observed=%0h expected=%0h", tag, coeffs_flat, pc);
    end
  endtask

  // last_at: -2 = s_last on the correct final word, -1 = never, else word index.
  // abort_at >= 0 stops after that many words (for mid-frame reset).
  task automatic send_frame(input bit reuse, input int last_at, input int abort_at,
                            output bit err_exp);
    bit ract;
    int len, lpos, nsend, v, guard;
    ract    = reuse & cf_loaded_m;
    len     = ract ? N : 2*N;
    lpos    = (last_at == -2) ? len - 1 : last_at;
    err_exp = (lpos != len - 1);
    nsend   = (lpos >= 0 && lpos < len) ? lpos + 1 : len;
    if (abort_at >= 0) nsend = abort_at;
    for (int j = 0; j < nsend; j++) begin
      @(negedge clk);
      if ($urandom_range(0, 3) == 0) begin
        sif.s_valid = 1'b0;
        @(negedge clk);
      end
      v = (j < N) ? frame_in[j] : frame_cf[j-N];
      sif.s_data       = W'(v);
      sif.s_valid      = 1'b1;
      sif.s_last       = (j == lpos);
      sif.reuse_coeffs = (j == 0) ? reuse : 1'($urandom);
      guard = 0;
      while (!sif.s_ready && guard < 20) begin
        @(negedge clk);
        guard++;
      end
      if (!sif.s_ready) chk("s_ready_timeout", 64'(sif.s_ready), 64'd1);
      @(posedge clk);
      if (j < N) ref_in[j] = v;
      else       ref_cf[j-N] = v;
    end
    if (abort_at < 0) begin
      if (err_exp) begin
        if (!ract && nsend - 1 >= N) cf_loaded_m = 1'b0;
      end else if (!ract) begin
        cf_loaded_m = 1'b1;
      end
    end
  endtask

  task automatic finish_result(input string tag, input int hold);
    logic signed [2*W:0] exp_r;
    exp_r = model_result();
    @(negedge clk);
    sif.s_valid = 1'b0;
    sif.s_last  = 1'b0;
    chk({tag, "_rv_k"}, 64'(sif.result_valid), 64'd0);
    chk({tag, "_sready_k"}, 64'(sif.s_ready), 64'd0);
    chk({tag, "_ferr"}, 64'(frame_err), 64'd0);
    repeat (SETTLE) begin
      @(negedge clk);
      chk({tag, "_rv_settle"}, 64'(sif.result_valid), 64'd0);
    end
    @(negedge clk);
    chk({tag, "_rv"}, 64'(sif.result_valid), 64'd1);
    chk({tag, "_data"}, 64'(sif.result_data), 64'(exp_r));
    chk_buses(tag);
    repeat (hold) begin
      @(negedge clk);
      chk({tag, "_hold_rv"}, 64'(sif.result_valid), 64'd1);
      chk({tag, "_hold_data"}, 64'(sif.result_data), 64'(exp_r));
      chk({tag, "_hold_sready"}, 64'(sif.s_ready), 64'd0);
    end
    sif.result_ready = 1'b1;
    @(posedge clk);
    #1;
    chk({tag, "_rv_clear"}, 64'(sif.result_valid), 64'd0);
    @(negedge clk);
    sif.result_ready = 1'b0;
    chk({tag, "_sready_back"}, 64'(sif.s_ready), 64'd1);
  endtask

  task automatic finish_error(input string tag);
    @(negedge clk);
    sif.s_valid = 1'b0;
    sif.s_last  = 1'b0;
    chk({tag, "_ferr_pulse"}, 64'(frame_err), 64'd1);
    chk({tag, "_rv"}, 64'(sif.result_valid), 64'd0);
    @(negedge clk);
    chk({tag, "_ferr_end"}, 64'(frame_err), 64'd0);
    chk({tag, "_sready"}, 64'(sif.s_ready), 64'd1);
    repeat (4) @(negedge clk);
    chk({tag, "_no_result"}, 64'(sif.result_valid), 64'd0);
  endtask

  task automatic load_t1();
    for (int i = 0; i < N; i++) begin
      frame_in[i] = (i == 0) ? 3 : 1;
      frame_cf[i] = (i == 0) ? 2 : 1;
    end
  endtask

  task automatic load_random();
    for (int i = 0; i < N; i++) begin
      frame_in[i] = int'($signed(16'($urandom)));
      frame_cf[i] = int'($signed(16'($urandom)));
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit e;
    rst = 1'b1;
    sif.s_data = '0; sif.s_valid = 1'b0; sif.s_last = 1'b0;
    sif.reuse_coeffs = 1'b0; sif.result_ready = 1'b0;
    cf_loaded_m = 1'b0;
    for (int i = 0; i < N; i++) begin ref_in[i] = 0; ref_cf[i] = 0; end

    repeat (3) @(negedge clk);
    chk("rst_sready", 64'(sif.s_ready), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_rv", 64'(sif.result_valid), 64'd0);
    chk("rst_rdata", 64'(sif.result_data), 64'd0);
    chk("rst_ferr", 64'(frame_err), 64'd0);
    chk("rst_sready_out", 64'(sif.s_ready), 64'd1);
    chk_buses("rst");

    // T1
    load_t1();
    send_frame(1'b0, -2, -1, e);
    chk("t1_err_exp", 64'(e), 64'd0);
    finish_result("t1", 0);
    chk("t1_value", 64'(model_result()), 64'(33'sd55));

    // T3: reuse coefficients, 50-word frame
    for (int i = 0; i < N; i++) frame_in[i] = 2;
    send_frame(1'b1, -2, -1, e);
    finish_result("t3", 0);
    chk("t3_value", 64'(model_result()), 64'(33'sd102));

    // T2: sign across all 33 bits
    for (int i = 0; i < N; i++) begin frame_in[i] = -1; frame_cf[i] = 32767; end
    send_frame(1'b0, -2, -1, e);
    finish_result("t2", 2);
    chk("t2_value", 64'(model_result()), 64'(-33'sd1638350));

    // T4: early s_last, then a clean T1 frame with T5 back-pressure
    load_t1();
    send_frame(1'b0, 10, -1, e);
    finish_error("t4");
    send_frame(1'b0, -2, -1, e);
    finish_result("t4t5", 5);

    // s_last missing on the final reuse word
    load_random();
    send_frame(1'b1, -1, -1, e);
    finish_error("nolast");

    // Early s_last during coefficients clears coeff_loaded; reuse request then needs 100 words
    load_random();
    send_frame(1'b0, 70, -1, e);
    finish_error("cf_err");
    load_random();
    send_frame(1'b1, -2, -1, e);
    finish_result("cf_err_next", 1);

    // T6: reset at word 60
    load_random();
    send_frame(1'b0, -2, 60, e);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("t6_sready", 64'(sif.s_ready), 64'd0);
    chk("t6_rv", 64'(sif.result_valid), 64'd0);
    chk("t6_ferr", 64'(frame_err), 64'd0);
    for (int i = 0; i < N; i++) begin ref_in[i] = 0; ref_cf[i] = 0; end
    cf_loaded_m = 1'b0;
    chk_buses("t6_rst");
    @(negedge clk);
    sif.s_valid = 1'b0;
    rst = 1'b0;
    load_random();
    send_frame(1'b1, -2, -1, e);
    finish_result("t6_next", 0);

    // Randomized frames
    for (int r = 0; r < 6; r++) begin
      load_random();
      send_frame(1'($urandom), -2, -1, e);
      finish_result("rand", int'($urandom_range(0, 3)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
